// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO: accepts sop/eop-framed words and exposes only committed packets.
// Optional statistics counters (pkt_in_cnt, pkt_drop_cnt) are built when PKT_FIFO_STATS_EN is defined.
module pkt_fifo #(
  parameter int DATA_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 4,
  parameter int PKT_CNT_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_sop,
  input  logic                     wr_eop,
  input  logic                     wr_vld,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     next_data,
  output logic                     ready,
  output logic                     sop,
  output logic                     eop,
  output logic                     vld,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     full,
  output logic                     drop,
  output logic                     overflow,
  output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
`ifdef PKT_FIFO_STATS_EN
  ,
  output logic [15:0]              pkt_in_cnt,
  output logic [15:0]              pkt_drop_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int EW    = DATA_WIDTH + 2;
  localparam logic [PW-1:0] OCC_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  // Handshake: the write side has no back-pressure; a word is taken whenever
  // wr_vld is high. The read side offers a word whenever vld (== ready) is high
  // and it is consumed on a cycle where vld && next_data.

  wr_state_t         state, state_n;
  logic [PW-1:0]     rptr, wptr, cptr;
  logic [PW-1:0]     rptr_n, wptr_n, cptr_n;
  logic [PW-1:0]     wr_addr;
  logic              we, commit, drop_n;
  logic [PW-1:0]     occ_w, occ_c, occ_n;
  logic              space_w, space_c;
  logic              rd_en, rd_eop;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt_n;
  logic [EW-1:0]     mem [0:DEPTH-1];
  logic [EW-1:0]     head;

  assign occ_w   = wptr - rptr;
  assign occ_c   = cptr - rptr;
  assign space_w = ~occ_w[ADDR_WIDTH];
  assign space_c = ~occ_c[ADDR_WIDTH];

  // Write FSM: next state, pointers and drop decision
  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    cptr_n  = cptr;
    wr_addr = wptr;
    we      = 1'b0;
    commit  = 1'b0;
    drop_n  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_vld && wr_sop) begin
          if (space_w) begin
            we     = 1'b1;
            wptr_n = wptr + PW'(1);
            if (wr_eop) begin
              commit = 1'b1;
              cptr_n = wptr + PW'(1);
            end else begin
              state_n = RECV;
            end
          end else begin
            drop_n  = 1'b1;
            state_n = wr_eop ? IDLE : DROP;
          end
        end
      end
      RECV: begin
        if (wr_vld && wr_sop) begin
          // Missing eop: discard the open packet and restart it at the commit point.
          drop_n  = 1'b1;
          wptr_n  = cptr;
          wr_addr = cptr;
          if (space_c) begin
            we     = 1'b1;
            wptr_n = cptr + PW'(1);
            if (wr_eop) begin
              commit  = 1'b1;
              cptr_n  = cptr + PW'(1);
              state_n = IDLE;
            end else begin
              state_n = RECV;
            end
          end else begin
            state_n = wr_eop ? IDLE : DROP;
          end
        end else if (wr_vld) begin
          if (space_w) begin
            we     = 1'b1;
            wptr_n = wptr + PW'(1);
            if (wr_eop) begin
              commit  = 1'b1;
              cptr_n  = wptr + PW'(1);
              state_n = IDLE;
            end
          end else begin
            drop_n  = 1'b1;
            wptr_n  = cptr;
            state_n = wr_eop ? IDLE : DROP;
          end
        end
      end
      DROP: begin
        if (wr_vld && wr_eop) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign head   = mem[rptr[ADDR_WIDTH-1:0]];
  assign rd_en  = ready && next_data;
  assign rd_eop = rd_en && head[DATA_WIDTH];
  assign rptr_n = rptr + (rd_en ? PW'(1) : PW'(0));
  assign occ_n  = wptr_n - rptr_n;

  // A commit and an eop read in the same cycle cancel out.
  always_comb begin
    pkt_cnt_n = pkt_cnt;
    if (commit && !rd_eop)      pkt_cnt_n = pkt_cnt + PKT_CNT_WIDTH'(1);
    else if (!commit && rd_eop) pkt_cnt_n = pkt_cnt - PKT_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rptr     <= '0;
      wptr     <= '0;
      cptr     <= '0;
      pkt_cnt  <= '0;
      ready    <= 1'b0;
      full     <= 1'b0;
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      rptr     <= rptr_n;
      wptr     <= wptr_n;
      cptr     <= cptr_n;
      pkt_cnt  <= pkt_cnt_n;
      ready    <= (pkt_cnt_n != '0);
      full     <= (occ_n == OCC_FULL);
      drop     <= drop_n;
      overflow <= overflow | drop_n;
    end
  end

  // Storage has no reset; only committed entries are ever presented.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_addr[ADDR_WIDTH-1:0]] <= {wr_sop, wr_eop, wr_data};
  end

  assign vld      = ready;
  assign sop      = ready & head[DATA_WIDTH+1];
  assign eop      = ready & head[DATA_WIDTH];
  assign out_data = ready ? head[DATA_WIDTH-1:0] : '0;

`ifdef PKT_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_in_cnt   <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (commit && pkt_in_cnt != 16'hFFFF)   pkt_in_cnt   <= pkt_in_cnt + 16'd1;
      if (drop_n && pkt_drop_cnt != 16'hFFFF) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pkt_fifo.md
Name: pkt_fifo

Overview:
Parametrised store-and-forward packet FIFO. It is the next generation of the single-priority ingress buffer that sits between the port write interface and the SRAM controller. It accepts sop/eop-framed words and presents only complete packets to the reader. A packet that does not fit is dropped whole by rewinding the write pointer; a partial packet never leaks downstream. Width and depth are parametrised, and it reports packet count, full, per-packet drop and sticky overflow.

Parameters:
DATA_WIDTH, 256, payload bits per word
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH words
PKT_CNT_WIDTH, ADDR_WIDTH+1, width of stored-packet counter

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
wr_sop  in  1  first word of packet (qualified by wr_vld)
wr_eop  in  1  last word of packet (qualified by wr_vld)
wr_vld  in  1  wr_data valid this cycle
wr_data  in  DATA_WIDTH  write payload
next_data  in  1  reader consumes current output word
ready  out  1  at least one complete packet stored
sop  out  1  output word is first of packet (0 when !ready)
eop  out  1  output word is last of packet (0 when !ready)
vld  out  1  equals ready
out_data  out  DATA_WIDTH  word at read pointer, combinational from storage
full  out  1  uncommitted write pointer minus read pointer == DEPTH
drop  out  1  one-cycle pulse: current packet discarded
overflow  out  1  sticky: any drop since reset
pkt_cnt  out  PKT_CNT_WIDTH  complete packets stored

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high; it is sampled only on posedge clk.
- Reset: rptr, wptr and cptr (commit pointer), all ADDR_WIDTH+1 bits, go to 0. State goes to IDLE. pkt_cnt, ready, full, drop and overflow go to 0. Storage is not cleared. sop, eop and vld read 0.
- Reset mid-packet aborts the packet silently: no drop pulse, overflow not set.
- Storage entry: {sop, eop, DATA_WIDTH data}.
- Occupancy is (wptr - rptr) in modulo-2^(ADDR_WIDTH+1) arithmetic. A word can be written only when occupancy < DEPTH.
- Write FSM states: IDLE, RECV, DROP.
- IDLE:
  - wr_vld & !wr_sop: word ignored.
  - wr_vld & wr_sop with space: write at wptr, wptr+1.
  - If wr_eop is also set (single-word packet): commit, stay IDLE. Otherwise go to RECV.
  - wr_vld & wr_sop with no space: drop pulse, overflow<=1. Go to DROP, or stay IDLE if wr_eop.
- RECV:
  - wr_vld with space: write, wptr+1.
  - On wr_eop: commit (cptr<=wptr+1, pkt_cnt+1), go to IDLE.
  - wr_vld with no space: wptr<=cptr (rewind), drop, overflow<=1. Go to DROP, or IDLE if wr_eop.
  - wr_vld & wr_sop (missing eop): rewind wptr to cptr, drop, overflow<=1. The new word is then treated as an IDLE sop, written at cptr.
- DROP: all words ignored until wr_vld & wr_eop, then go to IDLE. A wr_sop in DROP is ignored (its packet is also dropped).
- Read side:
  - When ready & next_data: rptr+1.
  - If the consumed entry has eop: pkt_cnt-1.
  - next_data while !ready is ignored.
  - The reader may only advance into committed words (guaranteed by ready = pkt_cnt != 0).
- Simultaneous commit and eop-read in one cycle: pkt_cnt unchanged.
- Space freed by a read is usable by a write in the next cycle, not the same cycle.
- Latency: ready rises the cycle after the eop word is written. out_data is valid in the same cycle ready is high.
- Pointer wrap: natural modulo arithmetic. The extra MSB distinguishes full from empty.
- full and ready are registered. drop is registered and high exactly one cycle per dropped packet.

Optional Feature:
- Macro: PKT_FIFO_STATS_EN.
- With macro: adds output pkt_in_cnt[15:0] (packets committed) and output pkt_drop_cnt[15:0] (drop pulses).
  - Both reset to 0 on rst.
  - Both saturate at 16'hFFFF.
  - Both are registered and update the cycle after the event.
- Without macro: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset, then one 3-word packet (sop on 0xA1, 0xA2, eop on 0xA3), next_data=0 -> ready=1 and pkt_cnt=1 the cycle after eop. out_data=0xA1, sop=1. Three next_data cycles yield 0xA2, then 0xA3 with eop=1, then ready=0, pkt_cnt=0.
- ADDR_WIDTH=4; write 20-word packet with no reads -> word 17 triggers drop=1 for one cycle, overflow=1. ready stays 0 through eop, wptr returns to 0. A following 2-word packet is stored and read back intact.
- Single-word packet (wr_sop=wr_eop=1, 0x55) in back-to-back cycles x4 -> pkt_cnt=4, read order 0x55 x4, each with sop=eop=1.
- Packet A words 1-2, then wr_sop of packet B without A's eop -> drop=1, B's words start at old cptr. Only B is readable, pkt_cnt=1.
- Stream 40 single-word packets while reading continuously -> pointer wrap is correct, no drop, data order preserved. Reading an eop word in the same cycle another packet commits keeps pkt_cnt unchanged.
- rst asserted mid-packet and during reading -> next cycle all outputs 0, drop=0, overflow=0. With PKT_FIFO_STATS_EN, counters are 0.
